// File: rtl/phase_bank.sv
// Double-buffered per-channel phase bank: host writes land in a shadow bank and are copied to the
// active bank only at a PWM period boundary after a commit. Optional readback port: PHASE_BANK_READBACK_EN.
module phase_bank #(
  parameter int NUM_CHANNELS = 64,
  parameter int PHASE_W      = 8,
  parameter int FRAME_CNT_W  = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            phase_parse_en,
  input  logic [31:0]                     latest_data,
  input  logic                            period_start,
  input  logic                            clear_error,
`ifdef PHASE_BANK_READBACK_EN
  input  logic [7:0]                      rd_channel,
  output logic [PHASE_W-1:0]              rd_phase,
`endif
  output logic [NUM_CHANNELS*PHASE_W-1:0] phases_out,
  output logic                            swap_pending,
  output logic                            swap_done,
  output logic                            parse_error,
  output logic [FRAME_CNT_W-1:0]          frame_count
);

  typedef enum logic {IDLE, PENDING} state_t;

  state_t state, state_nxt;

  logic [PHASE_W-1:0] shadow [NUM_CHANNELS];
  logic [PHASE_W-1:0] active [NUM_CHANNELS];

  logic [PHASE_W-1:0] phase;
  logic [8:0]         ch;
  logic               commit, bcast, ch_valid, write_err, swap_now, swap_q;
  logic               unused_bits;

  assign phase       = latest_data[PHASE_W-1:0];
  assign ch          = {1'b0, latest_data[15:8]};
  assign commit      = latest_data[16];
  assign bcast       = latest_data[17];
  assign ch_valid    = ch < 9'(NUM_CHANNELS);
  assign write_err   = phase_parse_en & ~bcast & ~ch_valid;
  assign unused_bits = ^{latest_data[31:18], latest_data[7:0]};

  always_comb begin
    state_nxt = state;
    swap_now  = 1'b0;
    case (state)
      IDLE:    if (phase_parse_en && commit) state_nxt = PENDING;
      PENDING: if (period_start) begin
        swap_now  = 1'b1;
        // a commit arriving on the swap edge re-arms for the next boundary
        state_nxt = (phase_parse_en && commit) ? PENDING : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CHANNELS; i++) shadow[i] <= '0;
    end else if (phase_parse_en) begin
      for (int i = 0; i < NUM_CHANNELS; i++)
        if (bcast || ch == 9'(i)) shadow[i] <= phase;
    end
  end

  // copy sees pre-edge shadow, so a write on the swap edge waits for the next boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CHANNELS; i++) active[i] <= '0;
    end else if (swap_now) begin
      for (int i = 0; i < NUM_CHANNELS; i++) active[i] <= shadow[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_count <= '0;
      swap_q      <= 1'b0;
      swap_done   <= 1'b0;
      parse_error <= 1'b0;
    end else begin
      if (swap_now) frame_count <= frame_count + 1'b1;
      swap_q    <= swap_now;
      swap_done <= swap_q;
      if (write_err)        parse_error <= 1'b1;
      else if (clear_error) parse_error <= 1'b0;
    end
  end

  always_comb begin
    phases_out = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) phases_out[i*PHASE_W +: PHASE_W] = active[i];
  end

  assign swap_pending = (state == PENDING);

`ifdef PHASE_BANK_READBACK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_phase <= '0;
    end else begin
      rd_phase <= '0;
      for (int i = 0; i < NUM_CHANNELS; i++)
        if ({1'b0, rd_channel} == 9'(i)) rd_phase <= active[i];
    end
  end
`endif

endmodule
